stage_md: RTL
=============

# stage_md

Parametrised multiply/divide unit for the execute stage. It runs beside the single-cycle ALU and implements MIPS mult/multu/div/divu/mthi/mtlo with HI/LO registers. It models a configurable multi-cycle latency with a busy handshake, so the hazard unit can stall dependent instructions. It also supports a cancel input, so an operation can be aborted when the issuing instruction is flushed.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 8)
- MULT_LAT, 5, busy cycles for mult/multu (≥ 1)
- DIV_LAT, 10, busy cycles for div/divu (≥ 1)
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  qualifies op for one cycle
- op  input  3  0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 nop
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- cancel  input  1  abort operation in flight
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse after HI/LO committed
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- **States:** IDLE, RUN. Down-counter cnt sized for max(MULT_LAT, DIV_LAT).
- **IDLE, start with op 1–4:**
  - Capture A, B, op and compute the result into holding registers.
  - Load cnt with the latency for that op; go to RUN.
  - hi/lo are unchanged at this point.
- **IDLE, start with op 5 (mthi):** hi ← A at that edge. Op 6 (mtlo): lo ← A at that edge. No busy, no done.
- **IDLE, start with op 0 or 7, or start low:** no effect.
- **RUN:**
  - cnt decrements each cycle.
  - On the edge where cnt reaches 0: commit the result to hi/lo, go to IDLE, set done for the next cycle.
- **start while in RUN:** ignored entirely, including mthi/mtlo. The hazard unit stalls instead.
- **cancel:**
  - cancel=1 in RUN: return to IDLE at that edge. hi/lo are not written, done is not asserted.
  - cancel=1 in IDLE: no effect.
  - cancel and start together in IDLE: start is ignored.
- **mult:** signed 2·WIDTH-bit product; hi = upper half, lo = lower half.
- **multu:** unsigned 2·WIDTH-bit product; hi = upper half, lo = lower half.
- **div:** signed, quotient truncated toward zero; lo = quotient, hi = remainder. The remainder takes the sign of the dividend.
- **divu:** unsigned; lo = quotient, hi = remainder.
- **Divide by zero (div/divu):** the full latency elapses, done pulses, and hi/lo stay unchanged.
- **Signed overflow (div of min-int by −1):** lo = min-int, hi = 0.
- **Reset asserted (low):**
  - hi=0, lo=0, busy=0, done=0, state IDLE, cnt=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.

## Timing
- busy is combinational from state (RUN).
- Start sampled at edge E0:
  - busy is high from just after E0 through edge E_LAT, i.e. exactly LAT cycles.
  - hi/lo take their new value after E_LAT.
  - done is high for the cycle following E_LAT.
- A new start is accepted on the edge immediately after busy falls. Back-to-back throughput is LAT+1 cycles per op.
- mthi/mtlo have 1-cycle latency and their value is visible the next cycle.
- hi and lo are registered outputs. There is no combinational path from inputs to hi/lo/done.
- The hazard unit must treat (busy | (start & op∈1..6)) as a stall condition for op 1–6 and for mfhi/mflo.

## Test plan
- **mult:** WIDTH=32, MULT_LAT=5; start, op=1, A=0xFFFFFFFD (−3), B=5.
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1, with done pulsing once.
- **multu:** op=2, A=0xFFFFFFFF, B=2 → hi=0x00000001, lo=0xFFFFFFFE.
- **div and divu:**
  - op=3, A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - op=3, A=0x80000000, B=0xFFFFFFFF → lo=0x80000000, hi=0.
  - op=4, A=7, B=0 with hi/lo preloaded to 0x11/0x22 → both unchanged, done still pulses.
- **mthi/mtlo and start-while-busy:**
  - mthi A=0xCAFE then mtlo A=0xBEEF → hi=0xCAFE, lo=0xBEEF one cycle each.
  - Then issue mult, and during busy issue mthi A=0x1234 → mthi ignored, hi = product upper half.
- **cancel:** start div (A=100, B=3) with hi/lo preloaded, then pulse cancel on busy cycle 4.
  - busy drops after that edge, done never pulses, hi/lo keep their preloaded values.
  - A new mult issued on the next cycle completes normally.
- **reset:** drive reset low asynchronously (between clock edges) during the 3rd busy cycle of a mult.
  - hi=lo=0, busy=0, done=0 immediately.
  - After release, no stale commit occurs.

Source files
------------

// File: rtl/stage_md.sv
// stage_md: multi-cycle multiply/divide unit with HI/LO registers.
// Executes mult/multu/div/divu with a configurable busy latency and
// mthi/mtlo with single-cycle latency. An in-flight operation can be
// aborted with cancel; its result is then dropped.
//
// Handshake: start/op are sampled on a rising edge only while busy is low
// and cancel is low. Once a multi-cycle op is accepted, busy is high for
// exactly LAT cycles; hi/lo update on the edge that ends busy and done
// pulses for the following cycle. start is ignored while busy is high.
module stage_md #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             state_dbg
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_we;

    // Combinational result of the op presented on the inputs
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   bs_safe;
    logic [WIDTH-1:0]   bu_safe;
    logic [WIDTH-1:0]   qs_mag;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   qu;
    logic [WIDTH-1:0]   ru;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic               nxt_we;
    logic [CNT_W-1:0]   nxt_lat;
    logic               is_md;

    assign busy      = (state == RUN);
    assign state_dbg = (state == RUN);

    // Compute product/quotient/remainder and the latency for the requested op
    always_comb begin
        prod_s  = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        prod_u  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        a_neg   = A[WIDTH-1];
        b_neg   = B[WIDTH-1];
        a_mag   = a_neg ? (~A + 1'b1) : A;
        b_mag   = b_neg ? (~B + 1'b1) : B;
        // Substitute a divisor of 1 for zero so the divider never sees /0;
        // the result is discarded through nxt_we in that case.
        bs_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        bu_safe = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : B;
        // Magnitude divide; min-int / -1 wraps back to min-int with rem 0.
        qs_mag  = a_mag / bs_safe;
        rs_mag  = a_mag % bs_safe;
        qu      = A / bu_safe;
        ru      = A % bu_safe;
        nxt_hi  = '0;
        nxt_lo  = '0;
        nxt_we  = 1'b0;
        nxt_lat = '0;
        is_md   = 1'b0;
        case (op)
            OP_MULT: begin
                nxt_hi  = prod_s[2*WIDTH-1:WIDTH];
                nxt_lo  = prod_s[WIDTH-1:0];
                nxt_we  = 1'b1;
                nxt_lat = CNT_W'(MULT_LAT);
                is_md   = 1'b1;
            end
            OP_MULTU: begin
                nxt_hi  = prod_u[2*WIDTH-1:WIDTH];
                nxt_lo  = prod_u[WIDTH-1:0];
                nxt_we  = 1'b1;
                nxt_lat = CNT_W'(MULT_LAT);
                is_md   = 1'b1;
            end
            OP_DIV: begin
                nxt_lo  = (a_neg ^ b_neg) ? (~qs_mag + 1'b1) : qs_mag;
                nxt_hi  = a_neg ? (~rs_mag + 1'b1) : rs_mag;
                nxt_we  = (B != '0);
                nxt_lat = CNT_W'(DIV_LAT);
                is_md   = 1'b1;
            end
            OP_DIVU: begin
                nxt_lo  = qu;
                nxt_hi  = ru;
                nxt_we  = (B != '0);
                nxt_lat = CNT_W'(DIV_LAT);
                is_md   = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM: accept ops in IDLE, count down in RUN, commit or abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_we <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (is_md) begin
                            res_hi <= nxt_hi;
                            res_lo <= nxt_lo;
                            res_we <= nxt_we;
                            cnt    <= nxt_lat;
                            state  <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi <= A;
                        end else if (op == OP_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        done  <= 1'b1;
                        if (res_we) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
